// File: rtl/memory_game_pkg.sv
// Shared types, constants and helpers for the LED memory game round controller.
package memory_game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    HIDE   = 3'd2,
    JUDGE  = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_e;

  localparam logic [7:0] SEG_MATCH = 8'hFF;
  localparam logic [7:0] SEG_MISS  = 8'h80;
  localparam logic [7:0] SEG_OVER  = 8'h40;
  localparam logic [7:0] SEG_OFF   = 8'h00;

  // Feedback taps q[7], q[5], q[4], q[3].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // XOR of the tapped LFSR bits.
  function automatic logic lfsr_feedback(input logic [7:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  // The target is the low six bits of the LFSR; the top two bits only feed back.
  function automatic logic [5:0] target_from_lfsr(input logic [7:0] q);
    return q[5:0];
  endfunction

  // Score increment that sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : (v + 4'd1);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the target pattern source.
module lfsr8
  import memory_game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_2,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Next value: shift left, new bit from the tap feedback.
  always_comb begin
    q_d = {q_q[6:0], lfsr_feedback(q_q)};
  end

  // LFSR register, reloads the seed on reset.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/memory_round_ctrl.sv
// Round controller for the binary LED memory game: target generation,
// show/hide timing, guess judging, score/lives/round tracking.
module memory_round_ctrl
  import memory_game_pkg::*;
#(
  parameter int         SHOW_CYCLES   = 8,
  parameter int         RESULT_CYCLES = 4,
  parameter int         NLIVES        = 3,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       start,
  input  logic       commit,
  input  logic [5:0] guess,
  output logic [7:0] led,
  output logic [7:0] seg,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [7:0] round,
  output logic       game_over,
  output logic [5:0] target_dbg
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] SHOW_LOAD   = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] RESULT_LOAD = TW'(RESULT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [1:0]    LIVES_INIT  = 2'(NLIVES);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    target_q, target_d;
  logic [5:0]    guess_q, guess_d;
  logic          match_q, match_d;
  logic [3:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    round_q, round_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    seg_q, seg_d;
  logic          game_over_q, game_over_d;
  logic          start_q, commit_q;
  logic          start_rise_s, commit_rise_s;
  logic [7:0]    lfsr_q;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_2 (clk_2),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign start_rise_s  = start & ~start_q;
  assign commit_rise_s = commit & ~commit_q;

  // Next-state, timer and score/lives/round bookkeeping.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    target_d = target_q;
    guess_d  = guess_q;
    match_d  = match_q;
    score_d  = score_q;
    lives_d  = lives_q;
    round_d  = round_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise_s) begin
          state_d  = SHOW;
          timer_d  = SHOW_LOAD;
          target_d = target_from_lfsr(lfsr_q);
          score_d  = 4'd0;
          lives_d  = LIVES_INIT;
          round_d  = 8'd1;
        end else begin
          state_d = state_q;
        end
      end
      SHOW: begin
        if (timer_q == TIMER_ZERO) begin
          state_d = HIDE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      HIDE: begin
        if (commit_rise_s) begin
          state_d = JUDGE;
          guess_d = guess;
        end else begin
          state_d = HIDE;
        end
      end
      JUDGE: begin
        state_d = RESULT;
        timer_d = RESULT_LOAD;
        if (guess_q == target_q) begin
          match_d = 1'b1;
          score_d = sat_inc4(score_q);
        end else begin
          match_d = 1'b0;
          // Never reached with zero lives, the guard only keeps the count from wrapping.
          lives_d = (lives_q == 2'd0) ? 2'd0 : (lives_q - 2'd1);
        end
      end
      RESULT: begin
        if (timer_q != TIMER_ZERO) begin
          timer_d = timer_q - TIMER_ONE;
        end else if (lives_q == 2'd0) begin
          state_d = OVER;
        end else begin
          state_d  = SHOW;
          timer_d  = SHOW_LOAD;
          target_d = target_from_lfsr(lfsr_q);
          round_d  = round_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    led_d       = 8'h00;
    seg_d       = SEG_OFF;
    game_over_d = 1'b0;
    case (state_d)
      SHOW: begin
        led_d = {2'b00, target_d};
      end
      RESULT: begin
        seg_d = match_d ? SEG_MATCH : SEG_MISS;
      end
      OVER: begin
        seg_d       = SEG_OVER;
        game_over_d = 1'b1;
      end
      default: begin
        led_d = 8'h00;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, output and edge-detect registers; edge history resets high so a held switch is not an edge.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      timer_q     <= TIMER_ZERO;
      target_q    <= 6'd0;
      guess_q     <= 6'd0;
      match_q     <= 1'b0;
      score_q     <= 4'd0;
      lives_q     <= LIVES_INIT;
      round_q     <= 8'd0;
      led_q       <= 8'h00;
      seg_q       <= SEG_OFF;
      game_over_q <= 1'b0;
      start_q     <= 1'b1;
      commit_q    <= 1'b1;
    end else begin
      timer_q     <= timer_d;
      target_q    <= target_d;
      guess_q     <= guess_d;
      match_q     <= match_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      round_q     <= round_d;
      led_q       <= led_d;
      seg_q       <= seg_d;
      game_over_q <= game_over_d;
      start_q     <= start;
      commit_q    <= commit;
    end
  end

  assign led        = led_q;
  assign seg        = seg_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign round      = round_q;
  assign game_over  = game_over_q;
  assign target_dbg = target_q;

endmodule
